// File: rtl/fault_injector_pkg.sv
// Shared definitions for the fault injector: register word indices, CTRL/STATUS bits, FSM states, LFSR constants.
package fault_injector_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DLY   = 3'd1,
    PULSE = 3'd2,
    GAP   = 3'd3
  } fi_state_e;

  // Word indices (byte offset >> 2)
  localparam logic [3:0] IDX_CTRL     = 4'd0;
  localparam logic [3:0] IDX_DELAY    = 4'd1;
  localparam logic [3:0] IDX_WIDTH    = 4'd2;
  localparam logic [3:0] IDX_PERIOD   = 4'd3;
  localparam logic [3:0] IDX_COUNT    = 4'd4;
  localparam logic [3:0] IDX_STATUS   = 4'd5;
  localparam logic [3:0] IDX_INJECTED = 4'd6;
  localparam logic [3:0] IDX_JITTER   = 4'd7;

  localparam int CTRL_START   = 0;
  localparam int CTRL_STOP    = 1;
  localparam int CTRL_TRIG_EN = 2;

  localparam int STATUS_BUSY = 0;

  // Taps 16,14,13,11 expressed for a right-shifting register: feedback = l[0]^l[2]^l[3]^l[5]
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  function automatic logic [31:0] apply_be(logic [31:0] old, logic [31:0] wd, logic [3:0] be);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) res[8*b +: 8] = be[b] ? wd[8*b +: 8] : old[8*b +: 8];
    return res;
  endfunction

endpackage

// File: rtl/fault_injector_lfsr.sv
// 16-bit Fibonacci LFSR used to jitter GAP lengths; free-running from reset.
module fi_lfsr
  import fault_injector_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic [15:0] lfsr_o
);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) lfsr_o <= LFSR_SEED;
    else         lfsr_o <= {^(lfsr_o & LFSR_TAPS), lfsr_o[15:1]};
  end

endmodule

// File: rtl/fault_injector.sv
// Memory-mapped fault-pulse generator driving error_o with programmable delay/width/gap/count.
// Optional GAP jitter via FAULT_INJECTOR_LFSR_EN (adds JITTER_MASK at 0x1C).
module fault_injector
  import fault_injector_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  data_req_i,
  output logic                  data_gnt_o,
  input  logic                  data_we_i,
  input  logic [3:0]            data_be_i,
  input  logic [ADDR_WIDTH-1:0] data_addr_i,
  input  logic [31:0]           data_wdata_i,
  output logic                  data_rvalid_o,
  output logic [31:0]           data_rdata_o,
  input  logic                  trig_i,
  output logic                  error_o,
  output logic                  busy_o
);

  fi_state_e   state, state_d;
  logic [31:0] cnt, cnt_d, issued, issued_d;
  logic [31:0] delay_q, width_q, period_q, count_q, injected_q;
  logic [31:0] sh_width, sh_period, sh_count;
  logic        trig_en, trig_q, arm_q, enter_pulse;
  logic [31:0] rd_val, gap_len, p_eff, cfg_w_m1, sh_w_m1;
  logic [3:0]  idx;
  logic        wr, start_wr, stop_wr, inj_clr, arm_go;
  logic        unused_addr;

`ifdef FAULT_INJECTOR_LFSR_EN
  logic [15:0] lfsr, jitter_q;
  fi_lfsr u_lfsr (.clk_i(clk_i), .rst_ni(rst_ni), .lfsr_o(lfsr));
  assign idx         = data_addr_i[5:2];
  assign unused_addr = ^{data_addr_i[ADDR_WIDTH-1:6], data_addr_i[1:0]};
  assign gap_len     = p_eff + {16'b0, lfsr & jitter_q};
`else
  assign idx         = {1'b0, data_addr_i[4:2]};
  assign unused_addr = ^{data_addr_i[ADDR_WIDTH-1:5], data_addr_i[1:0]};
  assign gap_len     = p_eff;
`endif

  assign data_gnt_o = data_req_i;
  assign busy_o     = (state != IDLE);
  assign error_o    = (state == PULSE);

  assign wr       = data_req_i & data_we_i;
  assign start_wr = wr && idx == IDX_CTRL && data_be_i[0] && data_wdata_i[CTRL_START];
  assign stop_wr  = wr && idx == IDX_CTRL && data_be_i[0] && data_wdata_i[CTRL_STOP];
  assign inj_clr  = wr && idx == IDX_INJECTED;
  assign arm_go   = arm_q && state == IDLE && !stop_wr;

  // Zero WIDTH/PERIOD behave as one cycle
  assign cfg_w_m1 = (width_q == '0) ? '0 : width_q - 32'd1;
  assign sh_w_m1  = (sh_width == '0) ? '0 : sh_width - 32'd1;
  assign p_eff    = (sh_period == '0) ? 32'd1 : sh_period;

  always_comb begin
    rd_val = '0;
    case (idx)
      IDX_CTRL:     rd_val[CTRL_TRIG_EN] = trig_en;
      IDX_DELAY:    rd_val = delay_q;
      IDX_WIDTH:    rd_val = width_q;
      IDX_PERIOD:   rd_val = period_q;
      IDX_COUNT:    rd_val = count_q;
      IDX_STATUS:   rd_val = {28'b0, state, busy_o};
      IDX_INJECTED: rd_val = injected_q;
`ifdef FAULT_INJECTOR_LFSR_EN
      IDX_JITTER:   rd_val = {16'b0, jitter_q};
`endif
      default:      rd_val = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_rvalid_o <= 1'b0;
      data_rdata_o  <= '0;
      trig_en       <= 1'b0;
      delay_q       <= '0;
      width_q       <= '0;
      period_q      <= '0;
      count_q       <= '0;
`ifdef FAULT_INJECTOR_LFSR_EN
      jitter_q      <= '0;
`endif
    end else begin
      data_rvalid_o <= data_req_i;
      data_rdata_o  <= (data_req_i && !data_we_i) ? rd_val : '0;
      if (wr) begin
        case (idx)
          IDX_CTRL:   if (data_be_i[0]) trig_en <= data_wdata_i[CTRL_TRIG_EN];
          IDX_DELAY:  delay_q  <= apply_be(delay_q, data_wdata_i, data_be_i);
          IDX_WIDTH:  width_q  <= apply_be(width_q, data_wdata_i, data_be_i);
          IDX_PERIOD: period_q <= apply_be(period_q, data_wdata_i, data_be_i);
          IDX_COUNT:  count_q  <= apply_be(count_q, data_wdata_i, data_be_i);
`ifdef FAULT_INJECTOR_LFSR_EN
          IDX_JITTER: jitter_q <= apply_be({16'b0, jitter_q}, data_wdata_i, data_be_i) & 32'h0000_FFFF;
`endif
          default: ;
        endcase
      end
    end
  end

  // Arm requests are registered, so the FSM leaves IDLE one edge after acceptance
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      trig_q <= 1'b0;
      arm_q  <= 1'b0;
    end else begin
      trig_q <= trig_i;
      arm_q  <= (start_wr || (trig_en && trig_i && !trig_q)) && !stop_wr && state == IDLE;
    end
  end

  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    issued_d    = issued;
    enter_pulse = 1'b0;
    case (state)
      IDLE: if (arm_q) begin
        issued_d = '0;
        if (delay_q == '0) begin
          state_d     = PULSE;
          cnt_d       = cfg_w_m1;
          enter_pulse = 1'b1;
        end else begin
          state_d = DLY;
          cnt_d   = delay_q - 32'd1;
        end
      end
      DLY, GAP: begin
        if (cnt == '0) begin
          state_d     = PULSE;
          cnt_d       = sh_w_m1;
          enter_pulse = 1'b1;
        end else cnt_d = cnt - 32'd1;
      end
      PULSE: begin
        if (cnt == '0) begin
          if (sh_count != '0 && issued == sh_count) state_d = IDLE;
          else begin
            state_d = GAP;
            cnt_d   = gap_len - 32'd1;
          end
        end else cnt_d = cnt - 32'd1;
      end
      default: state_d = IDLE;
    endcase
    if (enter_pulse) issued_d = issued_d + 32'd1;
    if (stop_wr) begin
      state_d     = IDLE;
      cnt_d       = '0;
      enter_pulse = 1'b0;
    end
  end

  // DELAY is consumed at the arm edge itself, so it needs no shadow copy
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= IDLE;
      cnt        <= '0;
      issued     <= '0;
      injected_q <= '0;
      sh_width   <= '0;
      sh_period  <= '0;
      sh_count   <= '0;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      issued <= issued_d;
      if (inj_clr)          injected_q <= '0;
      else if (enter_pulse) injected_q <= injected_q + 32'd1;
      if (arm_go) begin
        sh_width  <= width_q;
        sh_period <= period_q;
        sh_count  <= count_q;
      end
    end
  end

endmodule

// File: tb/tb_fault_injector.sv
// Scoreboarded bench for fault_injector: bus responses checked by a monitor, pulse trains checked cycle by cycle.
module tb_fault_injector;

  logic        clk_i = 1'b0, rst_ni = 1'b0;
  logic        data_req_i = 1'b0, data_we_i = 1'b0, trig_i = 1'b0;
  logic [3:0]  data_be_i = 4'h0;
  logic [31:0] data_addr_i = '0, data_wdata_i = '0;
  logic        data_gnt_o, data_rvalid_o, error_o, busy_o;
  logic [31:0] data_rdata_o;

  fault_injector #(.ADDR_WIDTH(32)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .data_req_i(data_req_i), .data_gnt_o(data_gnt_o),
    .data_we_i(data_we_i), .data_be_i(data_be_i), .data_addr_i(data_addr_i),
    .data_wdata_i(data_wdata_i), .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
    .trig_i(trig_i), .error_o(error_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct { logic [31:0] data; int due; string name; } exp_t;
  exp_t q[$];
  exp_t e;
  int checks = 0, errors = 0;
  int n, n2;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h (cyc %0d)", nm, got, exp, cyc);
    end
  endtask

  always @(negedge clk_i) begin
    if (data_req_i) chk("gnt", {31'b0, data_gnt_o}, 32'd1);
    if (data_rvalid_o) begin
      if (q.size() == 0) chk("spurious_rvalid", 32'd1, 32'd0);
      else begin
        e = q.pop_front();
        chk({e.name, "_rdata"}, data_rdata_o, e.data);
        chk({e.name, "_latency"}, cyc, e.due);
      end
    end
  end

  // One bus access in the cycle after the next negedge; n returns the accepting edge.
  task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b,
                     input logic [31:0] ex, input string nm, output int acc);
    int c;
    @(negedge clk_i);
    c = cyc;
    data_req_i = 1'b1; data_we_i = w; data_addr_i = a; data_wdata_i = d; data_be_i = b;
    q.push_back('{ex, c + 1, nm});
    @(posedge clk_i);
    acc = c + 1;
    #1;
    data_req_i = 1'b0; data_we_i = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b, output int acc);
    bus(1'b1, a, d, b, 32'd0, $sformatf("wr%0h", a), acc);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] ex, input string nm);
    int acc;
    bus(1'b0, a, 32'd0, 4'hF, ex, nm, acc);
  endtask

  task automatic cfg(input int d, input int w, input int p, input int c);
    int acc;
    wr(32'h04, d, 4'hF, acc); wr(32'h08, w, 4'hF, acc);
    wr(32'h0C, p, 4'hF, acc); wr(32'h10, c, 4'hF, acc);
  endtask

  // Expected waveform after arm accepted at edge a: pulses start at a+1+d, spaced w+p.
  task automatic wave(input string nm, input int a, input int d, input int w, input int p,
                      input int np, input int span);
    int first, per, last_fall, k;
    logic ee, eb;
    first = a + 1 + d; per = w + p; last_fall = first + (np - 1) * per + w;
    for (int t = a; t <= a + span; t++) begin
      @(negedge clk_i);
      k  = t - first;
      ee = (t >= first) && (k / per < np) && (k % per < w);
      eb = (t > a) && (t < last_fall);
      chk($sformatf("%s_error@%0d", nm, t - a), {31'b0, error_o}, {31'b0, ee});
      chk($sformatf("%s_busy@%0d", nm, t - a), {31'b0, busy_o}, {31'b0, eb});
    end
  endtask

`ifdef FAULT_INJECTOR_LFSR_EN
  task automatic jit(input logic [31:0] mask);
    int acc, run, pulses, mn, mx;
    logic prev;
    wr(32'h1C, mask, 4'hF, acc);
    cfg(0, 1, 2, 9);
    wr(32'h00, 32'h1, 4'h1, acc);
    run = 0; pulses = 0; mn = 1000; mx = 0; prev = 1'b0;
    for (int t = 0; t < 400 && (pulses < 9 || busy_o); t++) begin
      @(negedge clk_i);
      if (error_o && !prev) begin
        if (pulses > 0) begin
          if (mask == 0) chk("jit_gap_exact", run, 2);
          else chk("jit_gap_range", {31'b0, (run >= 2 && run <= 17)}, 32'd1);
          if (run < mn) mn = run;
          if (run > mx) mx = run;
        end
        pulses++;
        run = 0;
      end else if (!error_o) run++;
      prev = error_o;
    end
    chk("jit_pulses", pulses, 9);
    chk("jit_distinct", {31'b0, mx != mn}, {31'b0, mask != 0});
  endtask
`endif

  initial begin
    // Reset state
    repeat (2) @(negedge clk_i);
    chk("rst_error", {31'b0, error_o}, 32'd0);
    chk("rst_busy", {31'b0, busy_o}, 32'd0);
    chk("rst_rvalid", {31'b0, data_rvalid_o}, 32'd0);
    chk("rst_rdata", data_rdata_o, 32'd0);
    rst_ni = 1'b1;
    for (int i = 0; i < 8; i++) rd(i * 4, 32'd0, $sformatf("rst_reg%0d", i));

    // Single pulse, DELAY=5 WIDTH=2
    cfg(5, 2, 0, 1);
    wr(32'h00, 32'h1, 4'h1, n);
    wave("t1", n, 5, 2, 0, 1, 12);
    rd(32'h18, 32'd1, "t1_injected");
    rd(32'h14, 32'd0, "t1_status");
    rd(32'h00, 32'd0, "t1_ctrl");
    wr(32'h18, 32'hFFFF_FFFF, 4'h0, n);
    rd(32'h18, 32'd0, "inj_clear_be0");

    // Three pulses; a WIDTH write mid-run must not affect the active train
    cfg(0, 3, 4, 3);
    wr(32'h00, 32'h1, 4'h1, n);
    fork
      wave("t2", n, 0, 3, 4, 3, 22);
      begin repeat (3) @(negedge clk_i); wr(32'h08, 32'd1, 4'hF, n2); end
    join
    rd(32'h18, 32'd3, "t2_injected");

    // Unlimited train stopped after 10 pulses
    wr(32'h18, 32'd0, 4'hF, n);
    cfg(0, 1, 1, 0);
    wr(32'h00, 32'h1, 4'h1, n);
    wave("t3", n, 0, 1, 1, 1000, 19);
    wr(32'h00, 32'h2, 4'h1, n2);
    @(negedge clk_i);
    chk("t3_stop_error", {31'b0, error_o}, 32'd0);
    chk("t3_stop_busy", {31'b0, busy_o}, 32'd0);
    rd(32'h14, 32'd0, "t3_status");
    rd(32'h18, 32'd10, "t3_injected");

    // START and STOP together: stays idle
    wr(32'h00, 32'h3, 4'h1, n);
    repeat (3) @(negedge clk_i);
    chk("startstop_busy", {31'b0, busy_o}, 32'd0);

    // External trigger, DELAY=2; second rising edge while busy ignored
    wr(32'h18, 32'd0, 4'hF, n);
    cfg(2, 1, 0, 1);
    wr(32'h00, 32'h4, 4'h1, n);
    rd(32'h00, 32'h4, "ctrl_trig_en");
    @(negedge clk_i);
    n = cyc + 1;
    trig_i = 1'b1;
    fork
      wave("t4", n, 2, 1, 0, 1, 10);
      begin @(negedge clk_i); trig_i = 1'b0; @(negedge clk_i); trig_i = 1'b1; end
    join
    trig_i = 1'b0;
    rd(32'h18, 32'd1, "t4_injected");
    wr(32'h00, 32'h0, 4'h1, n);
    @(negedge clk_i); trig_i = 1'b1;
    repeat (3) @(negedge clk_i);
    chk("trig_disabled_busy", {31'b0, busy_o}, 32'd0);
    trig_i = 1'b0;

    // Back-to-back bus traffic, byte enables, unmapped addresses
    wr(32'h0C, 32'h1234, 4'hF, n);
    rd(32'h0C, 32'h1234, "period_b2b");
    wr(32'h0C, 32'hFFFF_FFAB, 4'h1, n);
    rd(32'h0C, 32'h12AB, "period_be");
    rd(32'h20, 32'd0, "addr20");
`ifdef FAULT_INJECTOR_LFSR_EN
    jit(32'h0);
    jit(32'hF);
`else
    wr(32'h1C, 32'hF, 4'hF, n);
    rd(32'h1C, 32'd0, "addr1c_unmapped");
`endif

    // Reset mid-pulse drops error_o without a clock edge
    cfg(0, 10, 0, 1);
    wr(32'h00, 32'h1, 4'h1, n);
    repeat (3) @(negedge clk_i);
    chk("pre_rst_error", {31'b0, error_o}, 32'd1);
    #1 rst_ni = 1'b0;
    #1;
    chk("async_rst_error", {31'b0, error_o}, 32'd0);
    chk("async_rst_busy", {31'b0, busy_o}, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    rd(32'h08, 32'd0, "post_rst_width");
    repeat (2) @(negedge clk_i);
    chk("queue_drained", q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule
